// File: rtl/gradient_window_3x3.sv
// gradient_window_3x3: streaming 3x3 magnitude/direction window builder for the NMS stage.
// Latency 1 cycle from the accepting edge to the registered window and valid strobe; no backpressure.
// Optional GRADIENT_WINDOW_SOF_EN adds in_sof to realign the raster position to (0,0).
module gradient_window_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
`ifdef GRADIENT_WINDOW_SOF_EN
  input  logic        in_sof,
`endif
  input  logic [10:0] in_magnitude,
  input  logic [1:0]  in_direction,
  output logic [98:0] gradient_magnitude,
  output logic [17:0] gradient_direction,
  output logic        gradient_data_valid
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic [10:0] mag;
    logic [1:0]  dir;
  } pix_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             vld_q, vld_d;
  pix_t             win_q [9];
  pix_t             win_d [9];

  // lb0 holds the previous row, lb1 the row before that; never reset
  pix_t             lb0 [IMG_WIDTH];
  pix_t             lb1 [IMG_WIDTH];

  logic             sof;
  logic [COL_W-1:0] addr;
  pix_t             pix_in;
  pix_t             lb_a;
  pix_t             lb_b;

  // Start-of-frame qualification and line buffer read (read happens before the same-edge write)
  always_comb begin
`ifdef GRADIENT_WINDOW_SOF_EN
    sof = in_valid & in_sof;
`else
    sof = 1'b0;
`endif
    // A start-of-frame pixel is column 0 regardless of where the counter thinks it is
    addr   = sof ? '0 : col_q;
    pix_in = '{mag: in_magnitude, dir: in_direction};
    lb_a   = lb1[addr];
    lb_b   = lb0[addr];
  end

  // Raster position of the next accepted pixel
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (sof) begin
      col_d = COL_W'(1);
      row_d = '0;
    end else if (in_valid) begin
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Window shift: slot k = 8 - (3r + c); each row moves one column left, new right column enters
  always_comb begin
    for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
    if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[8 - 3*r] = win_q[7 - 3*r];
        win_d[7 - 3*r] = win_q[6 - 3*r];
      end
      win_d[6] = lb_a;
      win_d[3] = lb_b;
      win_d[0] = pix_in;
    end
  end

  // Only a full interior window (bottom-right at row>=2, col>=2) earns a strobe
  always_comb begin
    vld_d = in_valid && !sof && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  end

  // Position, window and strobe state; reset wins over an incoming pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      vld_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      vld_q <= vld_d;
      for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
    end
  end

  // Line buffer update: previous row ages into lb1, incoming pixel lands in lb0
  always_ff @(posedge clk) begin
    if (!reset && in_valid) begin
      lb1[addr] <= lb_b;
      lb0[addr] <= pix_in;
    end
  end

  // Pack the window registers onto the output buses
  always_comb begin
    gradient_magnitude = '0;
    gradient_direction = '0;
    for (int k = 0; k < 9; k++) begin
      gradient_magnitude[11*k +: 11] = win_q[k].mag;
      gradient_direction[2*k +: 2]   = win_q[k].dir;
    end
    gradient_data_valid = vld_q;
  end

endmodule

// File: tb/tb_gradient_window_3x3.sv
// Testbench for gradient_window_3x3 with a 5x4 image: scoreboard queue of expected windows,
// popped by a negedge monitor whenever the strobe is seen; driver issues directed raster frames.
module tb_gradient_window_3x3;

  localparam int W = 5;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [10:0] in_magnitude;
  logic [1:0]  in_direction;
  logic [98:0] gradient_magnitude;
  logic [17:0] gradient_direction;
  logic        gradient_data_valid;
`ifdef GRADIENT_WINDOW_SOF_EN
  logic        in_sof;
  int          sof_mode;
  logic        idle_sof;
`endif

  always #5 clk = ~clk;

  gradient_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
`ifdef GRADIENT_WINDOW_SOF_EN
    .in_sof              (in_sof),
`endif
    .in_magnitude        (in_magnitude),
    .in_direction        (in_direction),
    .gradient_magnitude  (gradient_magnitude),
    .gradient_direction  (gradient_direction),
    .gradient_data_valid (gradient_data_valid)
  );

  typedef struct packed {
    logic [98:0] mag;
    logic [17:0] dir;
  } win_t;

  win_t exp_q[$];
  win_t last_exp;
  logic last_int;
  logic hand_en;
  logic hand_pend;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  int   mode;   // 0: 5r+c+base with dir (r+c)%4; 1: saturated 2047/3
  int   base;

  function automatic logic [10:0] pm(int r, int c);
    return (mode == 1) ? 11'd2047 : 11'(base + 5*r + c);
  endfunction

  function automatic logic [1:0] pd(int r, int c);
    return (mode == 1) ? 2'd3 : 2'((r + c) % 4);
  endfunction

  function automatic win_t expw(int r, int c);
    win_t w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        w.mag[11*(8-(3*i+j)) +: 11] = pm(r-2+i, c-2+j);
        w.dir[2*(8-(3*i+j)) +: 2]   = pd(r-2+i, c-2+j);
      end
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected window
  always @(negedge clk) begin
    if (gradient_data_valid !== 1'b0) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got valid=%b with no window expected", gradient_data_valid);
      end else begin
        win_t w;
        w = exp_q.pop_front();
        chk("win_mag", 128'(gradient_magnitude), 128'(w.mag));
        chk("win_dir", 128'(gradient_direction), 128'(w.dir));
      end
    end
  end

  task automatic send_pix(input int r, input int c);
    @(negedge clk);
    if (hand_pend) begin
      // Window with bottom-right (2,2) of the base-0 frame, worked out by hand
      chk("first_slot4_mag", 128'(gradient_magnitude[54:44]), 128'd6);
      chk("first_slot4_dir", 128'(gradient_direction[9:8]),   128'd2);
      chk("first_slot8_mag", 128'(gradient_magnitude[98:88]), 128'd0);
      chk("first_slot0_mag", 128'(gradient_magnitude[10:0]),  128'd12);
      chk("first_slot0_dir", 128'(gradient_direction[1:0]),   128'd0);
      chk("first_slot5_mag", 128'(gradient_magnitude[65:55]), 128'd5);
      chk("first_slot3_mag", 128'(gradient_magnitude[43:33]), 128'd7);
      hand_pend = 1'b0;
    end
    in_valid     = 1'b1;
    in_magnitude = pm(r, c);
    in_direction = pd(r, c);
`ifdef GRADIENT_WINDOW_SOF_EN
    in_sof = (sof_mode != 0) && (r == 0) && (c == 0);
`endif
    if (r >= 2 && c >= 2) begin
      last_exp = expw(r, c);
      exp_q.push_back(last_exp);
      last_int = 1'b1;
    end else begin
      last_int = 1'b0;
    end
    if (hand_en && r == 2 && c == 2) hand_pend = 1'b1;
  endtask

  // Idle cycles; after the first one the outputs must still show the last window
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i > 0 && last_int) begin
        chk("hold_mag", 128'(gradient_magnitude), 128'(last_exp.mag));
        chk("hold_dir", 128'(gradient_direction), 128'(last_exp.dir));
      end
      in_valid = 1'b0;
`ifdef GRADIENT_WINDOW_SOF_EN
      in_sof = idle_sof;
`endif
    end
  endtask

  task automatic frame(input logic gap);
    int cnt;
    cnt = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send_pix(r, c);
        cnt++;
        if (gap && (cnt % 2 == 0)) idle(3);
      end
  endtask

  task automatic finish_test(input string name, input int s0, input int nexp);
    idle(3);
    chk(name, 128'(n_strobe - s0), 128'(nexp));
    chk({name, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    int s0;
    reset = 1'b1; in_valid = 1'b0; in_magnitude = '0; in_direction = '0;
    last_int = 1'b0; hand_en = 1'b0; hand_pend = 1'b0; mode = 0; base = 0;
    last_exp = '0;
`ifdef GRADIENT_WINDOW_SOF_EN
    in_sof = 1'b0; sof_mode = 0; idle_sof = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_mag",   128'(gradient_magnitude),  128'd0);
    chk("reset_dir",   128'(gradient_direction),  128'd0);
    chk("reset_valid", 128'(gradient_data_valid), 128'd0);
    reset = 1'b0;

    // Continuous frame
    s0 = n_strobe; hand_en = 1'b1;
    frame(1'b0);
    hand_en = 1'b0;
    finish_test("t1_strobes", s0, 6);

    // Same frame with 3-cycle gaps after every second pixel
    s0 = n_strobe;
    frame(1'b1);
    finish_test("t2_strobes", s0, 6);

    // Two back-to-back frames, second one offset so stale data would show
    s0 = n_strobe;
    base = 0;  frame(1'b0);
    base = 20; frame(1'b0);
    finish_test("t3_strobes", s0, 12);

    // Mid-frame reset with a pixel presented in the reset cycle
    base = 0; s0 = n_strobe;
    for (int i = 0; i < 9; i++) send_pix(i / W, i % W);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_magnitude = 11'h7ff; in_direction = 2'd3;
    @(negedge clk);
    chk("midreset_mag",   128'(gradient_magnitude),  128'd0);
    chk("midreset_dir",   128'(gradient_direction),  128'd0);
    chk("midreset_valid", 128'(gradient_data_valid), 128'd0);
    reset = 1'b0; in_valid = 1'b0; last_int = 1'b0;
    base = 40;
    frame(1'b0);
    finish_test("t4_strobes", s0, 6);

    // Saturated magnitude / direction everywhere
    mode = 1; s0 = n_strobe;
    frame(1'b0);
    finish_test("t5_strobes", s0, 6);
    mode = 0; base = 0;

`ifdef GRADIENT_WINDOW_SOF_EN
    // Partial frame, then realign with in_sof on the first pixel of a full frame
    s0 = n_strobe;
    for (int i = 0; i < 7; i++) send_pix(i / W, i % W);
    sof_mode = 1;
    frame(1'b0);
    sof_mode = 0;
    finish_test("t6_sof_strobes", s0, 6);
    // in_sof without in_valid must not disturb the counters
    s0 = n_strobe;
    idle_sof = 1'b1; idle(2); idle_sof = 1'b0;
    frame(1'b0);
    finish_test("t6_idle_sof_strobes", s0, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
